// File: rtl/uart_frame_loader.sv
// Collects an N x N grayscale frame from the UART byte stream, validates it with
// a sync byte plus an 8-bit additive checksum, and hands it to the Sobel filter.
module uart_frame_loader #(
    parameter int          N              = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               filter_done,
    output logic [8*N*N-1:0]   matrix_out_flat,
    output logic               start,
    output logic               busy,
    output logic               err_checksum,
    output logic               err_timeout,
    output logic               err_overrun,
    output logic [7:0]         frames_ok
);

    localparam int NPIX  = N * N;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HUNT        = 2'd0,
        ST_RECV        = 2'd1,
        ST_CHECK       = 2'd2,
        ST_WAIT_FILTER = 2'd3
    } state_t;

    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

    state_t             state_r;
    state_t             next_state_s;
    logic [8*NPIX-1:0]  frame_buf_r;
    logic [8*NPIX-1:0]  matrix_r;
    logic [IDX_W-1:0]   idx_r;
    logic [7:0]         sum_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic [7:0]         frames_ok_r;
    logic               start_r;
    logic               busy_r;
    logic               err_checksum_r;
    logic               err_timeout_r;
    logic               err_overrun_r;

    logic               arm_s;
    logic               accept_s;
    logic               launch_s;
    logic               chk_err_s;
    logic               tmo_s;
    logic               ovr_s;
    logic               tick_s;
    logic               tmo_hit_s;

    // The idle counter would reach TIMEOUT_CYCLES on this edge.
    assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        next_state_s = state_r;
        arm_s        = 1'b0;
        accept_s     = 1'b0;
        launch_s     = 1'b0;
        chk_err_s    = 1'b0;
        tmo_s        = 1'b0;
        ovr_s        = 1'b0;
        tick_s       = 1'b0;
        case (state_r)
            ST_HUNT: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    arm_s        = 1'b1;
                    next_state_s = ST_RECV;
                end else begin
                    next_state_s = ST_HUNT;
                end
            end
            ST_RECV: begin
                if (rx_valid) begin
                    accept_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        next_state_s = ST_CHECK;
                    end else begin
                        next_state_s = ST_RECV;
                    end
                end else if (tmo_hit_s) begin
                    tmo_s        = 1'b1;
                    next_state_s = ST_HUNT;
                end else begin
                    tick_s = 1'b1;
                end
            end
            ST_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == sum_r) begin
                        launch_s     = 1'b1;
                        next_state_s = ST_WAIT_FILTER;
                    end else begin
                        chk_err_s    = 1'b1;
                        next_state_s = ST_HUNT;
                    end
                end else if (tmo_hit_s) begin
                    tmo_s        = 1'b1;
                    next_state_s = ST_HUNT;
                end else begin
                    tick_s = 1'b1;
                end
            end
            ST_WAIT_FILTER: begin
                // A byte landing with filter_done is still an overrun, never a sync.
                if (rx_valid) begin
                    ovr_s = 1'b1;
                end else begin
                    ovr_s = 1'b0;
                end
                if (filter_done) begin
                    next_state_s = ST_HUNT;
                end else begin
                    next_state_s = ST_WAIT_FILTER;
                end
            end
            default: begin
                next_state_s = ST_HUNT;
            end
        endcase
    end

    // Payload capture: pixel buffer, byte index and running checksum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_buf_r <= {(8*NPIX){1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            sum_r       <= 8'd0;
        end else if (arm_s) begin
            idx_r <= {IDX_W{1'b0}};
            sum_r <= 8'd0;
        end else if (accept_s) begin
            frame_buf_r[{idx_r, 3'b000} +: 8] <= rx_data;
            sum_r                             <= sum8(sum_r, rx_data);
            if (idx_r == LAST_IDX) begin
                idx_r <= {IDX_W{1'b0}};
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else begin
            idx_r <= idx_r;
        end
    end

    // Inter-byte idle counter; only runs while a frame is being received.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (tick_s) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end
    end

    // Held output frame and launch counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            matrix_r    <= {(8*NPIX){1'b0}};
            frames_ok_r <= 8'd0;
        end else if (launch_s) begin
            matrix_r    <= frame_buf_r;
            frames_ok_r <= frames_ok_r + 8'd1;
        end else begin
            matrix_r    <= matrix_r;
        end
    end

    // Registered status pulses and busy flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_r        <= 1'b0;
            busy_r         <= 1'b0;
            err_checksum_r <= 1'b0;
            err_timeout_r  <= 1'b0;
            err_overrun_r  <= 1'b0;
        end else begin
            start_r        <= launch_s;
            busy_r         <= (next_state_s != ST_HUNT);
            err_checksum_r <= chk_err_s;
            err_timeout_r  <= tmo_s;
            err_overrun_r  <= ovr_s;
        end
    end

    assign matrix_out_flat = matrix_r;
    assign start           = start_r;
    assign busy            = busy_r;
    assign err_checksum    = err_checksum_r;
    assign err_timeout     = err_timeout_r;
    assign err_overrun     = err_overrun_r;
    assign frames_ok       = frames_ok_r;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed plus randomized bench for uart_frame_loader with a frame-level
// reference model (sum of pixels mod 256, packed pixel image, launch count).
module tb_uart_frame_loader;

    localparam int         N    = 4;
    localparam int         NPIX = N * N;
    localparam int         W    = 8 * NPIX;
    localparam int         TMO  = 50;
    localparam logic [7:0] SYNC = 8'hAA;

    typedef logic [7:0] frame_t [NPIX];

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic          filter_done = 1'b0;
    logic [W-1:0]  matrix_out_flat;
    logic          start;
    logic          busy;
    logic          err_checksum;
    logic          err_timeout;
    logic          err_overrun;
    logic [7:0]    frames_ok;

    int            n_total = 0;
    int            n_pass = 0;
    int            n_fail = 0;
    int            n_start_seen = 0;
    int            exp_starts = 0;
    int            exp_frames = 0;
    logic [W-1:0]  exp_matrix = '0;

    uart_frame_loader #(.N(N), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .filter_done(filter_done), .matrix_out_flat(matrix_out_flat), .start(start),
        .busy(busy), .err_checksum(err_checksum), .err_timeout(err_timeout),
        .err_overrun(err_overrun), .frames_ok(frames_ok)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start === 1'b1) n_start_seen++;
    end

    function automatic logic [7:0] ref_sum(input frame_t px);
        int s = 0;
        for (int k = 0; k < NPIX; k++) s += int'(px[k]);
        return 8'(s % 256);
    endfunction

    function automatic logic [W-1:0] ref_pack(input frame_t px);
        logic [W-1:0] m = '0;
        for (int k = 0; k < NPIX; k++) m[k*8 +: 8] = px[k];
        return m;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic rand_frame(output frame_t px);
        for (int k = 0; k < NPIX; k++) px[k] = 8'($urandom_range(0, 255));
    endtask

    // Sends the checksum and checks the outcome the model predicts.
    task automatic finish_frame(input frame_t px, input logic [7:0] cks, input string tag);
        send_byte(cks);
        if (cks == ref_sum(px)) begin
            exp_matrix = ref_pack(px);
            exp_frames++;
            exp_starts++;
            check({tag, "_start"}, W'(start), W'(1'b1));
            check({tag, "_matrix"}, matrix_out_flat, exp_matrix);
            check({tag, "_frames_ok"}, W'(frames_ok), W'(exp_frames % 256));
            check({tag, "_busy"}, W'(busy), W'(1'b1));
            filter_done = 1'b1;
            @(negedge clk);
            filter_done = 1'b0;
            check({tag, "_start_low"}, W'(start), W'(1'b0));
            check({tag, "_busy_low"}, W'(busy), W'(1'b0));
        end else begin
            check({tag, "_err_cks"}, W'(err_checksum), W'(1'b1));
            check({tag, "_no_start"}, W'(start), W'(1'b0));
            check({tag, "_held"}, matrix_out_flat, exp_matrix);
            check({tag, "_busy_low"}, W'(busy), W'(1'b0));
            @(negedge clk);
            check({tag, "_err_cks_low"}, W'(err_checksum), W'(1'b0));
        end
    endtask

    task automatic run_frame(input frame_t px, input logic [7:0] cks, input string tag);
        send_byte(SYNC);
        for (int k = 0; k < NPIX; k++) send_byte(px[k]);
        finish_frame(px, cks, tag);
    endtask

    initial begin
        frame_t px;
        int     k;
        int     tmo_seen;
        int     iter;
        logic [7:0] cks;

        repeat (3) @(negedge clk);
        check("rst_matrix", matrix_out_flat, '0);
        check("rst_flags", W'({start, busy, err_checksum, err_timeout, err_overrun}), W'(5'b0));
        check("rst_frames_ok", W'(frames_ok), W'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Ramp frame, good and then corrupted checksum.
        for (int i = 0; i < NPIX; i++) px[i] = 8'(i);
        run_frame(px, 8'h78, "ramp");
        run_frame(px, 8'h77, "ramp_bad");

        // Garbage before sync, then an all-0xFF frame.
        send_byte(8'h12);
        send_byte(8'h55);
        check("garbage_busy", W'(busy), W'(1'b0));
        for (int i = 0; i < NPIX; i++) px[i] = 8'hFF;
        run_frame(px, 8'hF0, "ones");

        // Silence after five pixels must time out exactly TMO cycles later.
        rand_frame(px);
        send_byte(SYNC);
        for (int i = 0; i < 5; i++) send_byte(px[i]);
        k = 0;
        tmo_seen = 0;
        while (tmo_seen == 0 && k < 200) begin
            @(negedge clk);
            k++;
            if (err_timeout === 1'b1) tmo_seen = 1;
        end
        check("tmo_latency", W'(k), W'(TMO));
        check("tmo_busy", W'(busy), W'(1'b0));
        check("tmo_held", matrix_out_flat, exp_matrix);
        @(negedge clk);
        check("tmo_pulse_low", W'(err_timeout), W'(1'b0));

        // A byte arriving exactly on the expiry cycle keeps the frame alive.
        rand_frame(px);
        send_byte(SYNC);
        for (int i = 0; i < 5; i++) send_byte(px[i]);
        tmo_seen = 0;
        for (int i = 0; i < TMO - 1; i++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) tmo_seen++;
        end
        send_byte(px[5]);
        if (err_timeout === 1'b1) tmo_seen++;
        check("tmo_edge_none", W'(tmo_seen), W'(0));
        check("tmo_edge_busy", W'(busy), W'(1'b1));
        for (int i = 6; i < NPIX; i++) send_byte(px[i]);
        finish_frame(px, ref_sum(px), "tmo_edge");

        // Overrun: bytes during WAIT_FILTER are dropped, including a sync.
        rand_frame(px);
        send_byte(SYNC);
        for (int i = 0; i < NPIX; i++) send_byte(px[i]);
        send_byte(ref_sum(px));
        exp_matrix = ref_pack(px);
        exp_frames++;
        exp_starts++;
        check("ovr_start", W'(start), W'(1'b1));
        for (int i = 0; i < 3; i++) begin
            send_byte((i == 1) ? SYNC : 8'($urandom_range(0, 255)));
            check("ovr_pulse", W'(err_overrun), W'(1'b1));
            check("ovr_held", matrix_out_flat, exp_matrix);
        end
        check("ovr_busy", W'(busy), W'(1'b1));
        filter_done = 1'b1;
        send_byte(SYNC);
        filter_done = 1'b0;
        check("ovr_coincide_pulse", W'(err_overrun), W'(1'b0) | W'(1'b1));
        check("ovr_coincide_busy", W'(busy), W'(1'b0));
        send_byte(8'h00);
        check("ovr_not_sync", W'(busy), W'(1'b0));
        rand_frame(px);
        run_frame(px, ref_sum(px), "after_ovr");

        // Reset in the middle of a frame.
        rand_frame(px);
        send_byte(SYNC);
        for (int i = 0; i < 7; i++) send_byte(px[i]);
        #3 reset_n = 1'b0;
        #1;
        exp_frames = 0;
        exp_matrix = '0;
        check("mid_rst_matrix", matrix_out_flat, '0);
        check("mid_rst_flags", W'({start, busy, err_checksum, err_timeout, err_overrun}), W'(5'b0));
        check("mid_rst_frames_ok", W'(frames_ok), W'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rand_frame(px);
        run_frame(px, ref_sum(px), "post_rst");

        // Random frames, occasionally corrupted, until the launch count wraps.
        iter = 0;
        while (exp_frames < 256 && iter < 400) begin
            rand_frame(px);
            cks = ref_sum(px);
            if ($urandom_range(0, 7) == 0) cks = cks ^ 8'(1 << $urandom_range(0, 7));
            run_frame(px, cks, "rand");
            iter++;
        end
        check("wrap_reached", W'(exp_frames), W'(256));
        check("wrap_frames_ok", W'(frames_ok), W'(0));

        repeat (3) @(negedge clk);
        #1;
        check("start_pulse_count", W'(n_start_seen), W'(exp_starts));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
